// File: rtl/alu_op_sequencer.sv
// Issue-side sequencer for the ALU result mux: accepts a function code, holds the
// select code for the op's duration, then handshakes the result. Option: ALU_SEQ_ILLEGAL_TRAP_EN.
module alu_op_sequencer #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_funct,
  output logic [2:0] alu_op,
  output logic       op_busy,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] FUNCT_MUL = 4'd2;
  localparam logic [3:0] CNT_INIT  = 4'(MUL_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [2:0] op_dec;

  always_comb begin
    op_dec = 3'b011;
    case (req_funct)
      4'd0:    op_dec = 3'b000;
      4'd1:    op_dec = 3'b001;
      4'd2:    op_dec = 3'b010;
      4'd3:    op_dec = 3'b100;
      4'd4:    op_dec = 3'b101;
      4'd5:    op_dec = 3'b110;
      default: op_dec = 3'b011;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d = op_dec;
          if (req_funct == FUNCT_MUL) begin
            state_d = EXEC;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      EXEC: begin
        // The counter only moves while non-zero, so it can never wrap.
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic ill_q, ill_d;

  always_comb begin
    ill_d = ill_q;
    if ((state_q == IDLE) && req_valid) begin
      ill_d = (req_funct > 4'd5);
    end else if ((state_q == RESP) && rsp_ready) begin
      ill_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_q <= 1'b0;
    end else begin
      ill_q <= ill_d;
    end
  end

  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif

  assign req_ready = (state_q == IDLE);
  assign op_busy   = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign alu_op    = op_q;

endmodule
